npc_predictor: RTL
==================

Name: npc_predictor

Overview:
- Sequential successor to the combinational next-PC control.
- Owns the fetch PC register and predicts next PC through a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Accepts branch/jump resolutions from the decode/execute stage, updates the BTB, and redirects fetch and raises flush on mispredict.
- Sits between IF (drives the instruction-memory address) and the stage that resolves branches.

Parameters:
- ENTRIES, 16, number of BTB entries; power of 2, range 2..256.
- TAG_W, 8, stored tag bits per entry.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC; lookup output still valid.
- pc  output  32  current fetch PC (register).
- pred_taken  output  1  prediction for pc; travels down the pipe with the instruction.
- pred_target  output  32  predicted target for pc (pc+4 when not taken).
- res_valid  input  1  resolution strobe, one cycle per control-flow instruction.
- res_pc  input  32  PC of the resolved instruction.
- res_taken  input  1  actual outcome (jumps always 1).
- res_target  input  32  actual taken target.
- res_pred_taken  input  1  pred_taken carried with that instruction.
- res_pred_target  input  32  pred_target carried with that instruction.
- flush  output  1  combinational; younger instructions must be squashed.

Behaviour:
- IDX_W = clog2(ENTRIES).
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Same slicing for res_pc.
- Entry fields: valid, tag, target[31:2] (low 2 bits implicitly 00), cnt[1:0].
- Lookup is combinational on pc.
  - hit = valid & tag match.
  - pred_taken = hit & cnt[1].
  - pred_target = pred_taken ? {target,2'b00} : pc+4.
  - Additions wrap mod 2^32.
- mispredict = res_valid & ((res_taken != res_pred_taken) | (res_taken & (res_target != res_pred_target))).
- flush = mispredict, in the same cycle as res_valid.
- Next-PC priority, highest first:
  1. reset -> RESET_PC.
  2. mispredict -> (res_taken ? res_target : res_pc+4). Overrides stall.
  3. stall -> hold pc.
  4. otherwise -> pred_target.
- BTB update on res_valid, written at the clock edge:
  - Resolved entry hits:
    - cnt saturates up if res_taken, down otherwise: 11 stays 11, 00 stays 00.
    - If res_taken, target is rewritten with res_target.
  - Resolved entry misses and res_taken: allocate (overwrite) with valid=1, tag, target, cnt=10.
  - Resolved entry misses and not taken: no write.
- The update does not depend on stall.
- Lookup and update hitting the same index in the same cycle: lookup sees pre-update contents; the write is visible next cycle.
- Reset:
  - pc = RESET_PC.
  - All valid bits = 0, all cnt = 01.
  - flush and pred_taken = 0 during the reset cycle.
  - Reset asserted mid-operation discards any same-cycle resolution.
- Latency: redirect takes effect on the cycle after res_valid (pc updates at that edge). A BTB hit redirects with zero bubbles.

Optional Feature:
- Macro: NPC_PERF_EN.
- When defined, adds two outputs:
  - perf_branches [31:0]: counts res_valid.
  - perf_mispred [31:0]: counts mispredict.
  - Both clear on reset and saturate at 32'hFFFF_FFFF.
- When undefined, neither the ports nor the logic exist; all other behaviour is identical.

Decomposition:
- Package npc_pkg holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - default RESET_PC;
  - index/tag slicing functions.
- One sub-module: npc_btb_array. It holds the storage arrays and provides one combinational read port and one synchronous write port, with read-old-data semantics on same-address access.

Test Plan:
- Reset check: after reset with no stimulus, pc steps 0x3000, 0x3004, 0x3008; pred_taken=0; flush=0.
- Cold taken branch: res_valid for res_pc=0x3010, res_taken=1, res_target=0x3040, pred_taken=0 -> flush=1 that cycle; pc=0x3040 next cycle. On the next fetch of 0x3010: pred_taken=1, pred_target=0x3040.
- Counter saturation: resolve 0x3010 taken 3 times (cnt reaches 11), then not-taken once. Still predicts taken (cnt=10). A second not-taken gives cnt=01 and pred_taken=0.
- Wrong target: entry predicts 0x3040, res_target=0x3080 -> flush=1, pc=0x3080, entry target updated to 0x3080.
- Stall vs mispredict: stall=1 with a mispredict in the same cycle -> pc takes the redirect. With stall=1 and no mispredict, pc holds for 3 cycles.
- Aliasing with ENTRIES=16: 0x3010 and 0x3010+0x40 share an index. Allocating the second overwrites the first, and a lookup of the first now misses on tag. With NPC_PERF_EN, the counters match the number of resolutions and flushes applied.

Source files
------------

// File: rtl/npc_pkg.sv
// -----------------------------------------------------------------------------
// npc_pkg
// Shared definitions for the next-PC predictor:
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   - default reset PC
//   - BTB index/tag slicing helpers and the counter update function
// No ports (package).
// -----------------------------------------------------------------------------
package npc_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t SNT = 2'b00;  // strongly not taken
    localparam cnt_t WNT = 2'b01;  // weakly not taken (reset value)
    localparam cnt_t WT  = 2'b10;  // weakly taken (allocation value)
    localparam cnt_t ST  = 2'b11;  // strongly taken

    localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;

    // Word index into the BTB: addr[idx_w+1:2], returned zero-extended.
    function automatic logic [31:0] btb_index(input logic [31:0] addr,
                                              input int unsigned idx_w);
        return (addr >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag bits above the index: addr[idx_w+tag_w+1:idx_w+2], zero-extended.
    function automatic logic [31:0] btb_tag(input logic [31:0] addr,
                                            input int unsigned idx_w,
                                            input int unsigned tag_w);
        return (addr >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic cnt_t cnt_update(input cnt_t cnt, input logic taken);
        cnt_t res;
        res = cnt;
        if (taken && (cnt != ST)) begin
            res = cnt + 2'd1;
        end else if (!taken && (cnt != SNT)) begin
            res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/npc_btb_array.sv
// -----------------------------------------------------------------------------
// npc_btb_array
// Direct-mapped BTB storage with one combinational lookup read port and one
// synchronous update port. The update port takes a branch resolution and
// performs the read-modify-write of the addressed entry internally (counter
// step / target rewrite on hit, allocation on a taken miss). A lookup of the
// index being written in the same cycle returns the old contents.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset (clears valid,
//                       sets every counter to WNT; discards a same-cycle update)
//   rd_idx_i            lookup index
//   rd_valid_o/rd_tag_o/rd_target_o/rd_cnt_o   lookup entry contents
//   wr_en_i             resolution strobe
//   wr_idx_i/wr_tag_i   index/tag of the resolved instruction
//   wr_taken_i          resolved outcome
//   wr_target_i         resolved target, word address (bits [31:2])
// -----------------------------------------------------------------------------
module npc_btb_array
    import npc_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [29:0]      rd_target_o,
    output logic [1:0]       rd_cnt_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             wr_taken_i,
    input  logic [29:0]      wr_target_i
);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [29:0]      target_q [ENTRIES];
    cnt_t             cnt_q    [ENTRIES];

    logic upd_hit;
    cnt_t upd_cnt_d;

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];
    assign rd_cnt_o    = cnt_q[rd_idx_i];

    assign upd_hit   = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);
    assign upd_cnt_d = cnt_update(cnt_q[wr_idx_i], wr_taken_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= WNT;
            end
        end else if (wr_en_i) begin
            if (upd_hit) begin
                cnt_q[wr_idx_i] <= upd_cnt_d;
                if (wr_taken_i) begin
                    target_q[wr_idx_i] <= wr_target_i;
                end
            end else if (wr_taken_i) begin
                // Taken miss: replace whatever lived at this index.
                valid_q[wr_idx_i]  <= 1'b1;
                tag_q[wr_idx_i]    <= wr_tag_i;
                target_q[wr_idx_i] <= wr_target_i;
                cnt_q[wr_idx_i]    <= WT;
            end
        end
    end

endmodule

// File: rtl/npc_predictor.sv
// -----------------------------------------------------------------------------
// npc_predictor
// Fetch PC register with BTB-based next-PC prediction. Lookup on the current
// PC is combinational; branch resolutions update the BTB at the clock edge and
// on a mispredict redirect fetch (next cycle) and raise flush (same cycle).
//
// Optional feature (macro NPC_PERF_EN): adds saturating performance counters
// perf_branches (resolutions) and perf_mispred (mispredicts).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   stall             hold PC (lookup outputs stay valid)
//   pc                current fetch PC
//   pred_taken        prediction for pc
//   pred_target       predicted next PC for pc (pc+4 when not taken)
//   res_valid         resolution strobe
//   res_pc            PC of the resolved instruction
//   res_taken         actual outcome
//   res_target        actual taken target
//   res_pred_taken    prediction carried with the instruction
//   res_pred_target   predicted target carried with the instruction
//   flush             combinational squash request on mispredict
//   perf_branches     [NPC_PERF_EN] count of resolutions
//   perf_mispred      [NPC_PERF_EN] count of mispredicts
// -----------------------------------------------------------------------------
module npc_predictor
    import npc_pkg::*;
#(
    parameter int          ENTRIES  = 16,
    parameter int          TAG_W    = 8,
    parameter logic [31:0] RESET_PC = NPC_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic        flush
`ifdef NPC_PERF_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispred
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc_plus4;
    logic [IDX_W-1:0] lk_idx, res_idx;
    logic [TAG_W-1:0] lk_tag, res_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [29:0]      rd_target;
    logic [1:0]       rd_cnt;
    logic             lk_hit;
    logic             mispredict;
    logic [31:0]      redirect_pc;

    assign lk_idx  = IDX_W'(btb_index(pc_q, IDX_W));
    assign lk_tag  = TAG_W'(btb_tag(pc_q, IDX_W, TAG_W));
    assign res_idx = IDX_W'(btb_index(res_pc, IDX_W));
    assign res_tag = TAG_W'(btb_tag(res_pc, IDX_W, TAG_W));

    npc_btb_array #(
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .rd_idx_i    (lk_idx),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .rd_cnt_o    (rd_cnt),
        .wr_en_i     (res_valid),
        .wr_idx_i    (res_idx),
        .wr_tag_i    (res_tag),
        .wr_taken_i  (res_taken),
        .wr_target_i (res_target[31:2])
    );

    // Lookup on the current PC; prediction is forced off while in reset.
    assign pc_plus4    = pc_q + 32'd4;
    assign lk_hit      = rd_valid && (rd_tag == lk_tag);
    assign pred_taken  = !reset && lk_hit && rd_cnt[1];
    assign pred_target = pred_taken ? {rd_target, 2'b00} : pc_plus4;
    assign pc          = pc_q;

    // A correct direction with a wrong target still mispredicts when taken.
    assign mispredict  = res_valid &&
                         ((res_taken != res_pred_taken) ||
                          (res_taken && (res_target != res_pred_target)));
    assign flush       = mispredict && !reset;
    assign redirect_pc = res_taken ? res_target : (res_pc + 32'd4);

    always_comb begin
        pc_d = pred_target;
        if (reset) begin
            pc_d = RESET_PC;
        end else if (mispredict) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

`ifdef NPC_PERF_EN
    logic [31:0] branches_q, branches_d;
    logic [31:0] mispred_q, mispred_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
        return (en && (val != 32'hFFFF_FFFF)) ? (val + 32'd1) : val;
    endfunction

    assign branches_d = sat_inc(branches_q, res_valid);
    assign mispred_d  = sat_inc(mispred_q, mispredict);

    always_ff @(posedge clk) begin
        if (reset) begin
            branches_q <= 32'd0;
            mispred_q  <= 32'd0;
        end else begin
            branches_q <= branches_d;
            mispred_q  <= mispred_d;
        end
    end

    assign perf_branches = branches_q;
    assign perf_mispred  = mispred_q;
`endif

endmodule
